// File: rtl/rc_filter_bank.sv
// rc_filter_bank: time-multiplexed bank of first-order RC filters that share one multiplier.
// Each channel is high-pass or low-pass according to HP_MASK.
// A frame latches every input on audio_clk_en and then updates one channel per clock.
// After the last channel, all outputs are published together with a one-cycle out_valid.
// Optional macro RC_FILTER_BANK_DITHER_EN enables an 8-bit LFSR.
// The LFSR dithers the stored previous input of the high-pass channels.
`timescale 1ns/1ps

module rc_filter_bank #(
    parameter int                  CHANNELS     = 2,
    parameter int                  WIDTH        = 16,
    parameter int                  SAMPLE_RATE  = 48000,
    parameter int                  R            = 47000,
    parameter int                  C_35_SHIFTED = 1615,
    parameter logic [CHANNELS-1:0] HP_MASK      = {CHANNELS{1'b1}}
) (
    input  logic                      clk,
    input  logic                      I_RSTn,
    input  logic                      audio_clk_en,
    input  logic [CHANNELS*WIDTH-1:0] in,
    output logic [CHANNELS*WIDTH-1:0] out,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      overrun
);

    // Filter coefficients are fixed at elaboration; 64-bit math avoids overflow of RC<<16.
    localparam longint DT_L   = (longint'(1) << 32) / longint'(SAMPLE_RATE);
    localparam longint RC_L   = (longint'(R) * longint'(C_35_SHIFTED)) >>> 3;
    localparam longint A_HP_L = (RC_L << 16) / (RC_L + DT_L);
    localparam longint A_LP_L = (DT_L << 16) / (RC_L + DT_L);

    localparam int SW  = WIDTH + 2;     // sum / difference width
    localparam int PW  = WIDTH + 19;    // product width
    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic signed [PW-1:0] A_HP = PW'(A_HP_L);
    localparam logic signed [PW-1:0] A_LP = PW'(A_LP_L);
    localparam logic signed [PW-1:0] MAXV = PW'((longint'(1) << (WIDTH - 1)) - 1);
    localparam logic signed [PW-1:0] MINV = -MAXV - PW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CHW-1:0]    ch_q, ch_d;
    logic              out_valid_q;
    logic              overrun_q;

    logic              latch_en;
    logic              run_en;

    // Flat views of the per-channel registers, used by the shared datapath mux.
    logic [CHANNELS*WIDTH-1:0] x_all;
    logic [CHANNELS*WIDTH-1:0] y_all;
    logic [CHANNELS*SW-1:0]    xp_all;

    // Shared datapath signals.
    logic signed [WIDTH-1:0] x_sel, y_sel;
    logic signed [SW-1:0]    xp_sel;
    logic signed [SW-1:0]    x_e, y_e, operand;
    logic signed [PW-1:0]    coef, prod, scaled, y_full;
    logic signed [WIDTH-1:0] y_next;
    logic signed [SW-1:0]    xp_next;
    logic signed [SW-1:0]    dither;
    logic                    is_hp;

    assign latch_en  = (state_q == IDLE) && audio_clk_en;
    assign run_en    = (state_q == RUN);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

`ifdef RC_FILTER_BANK_DITHER_EN
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_frame_q;

    // The LFSR steps on every strobe; a copy is frozen at frame start so all channels see one value.
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            lfsr_q       <= 8'h01;
            lfsr_frame_q <= 8'h00;
        end else begin
            if (audio_clk_en) begin
                lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            end
            if (latch_en) begin
                lfsr_frame_q <= lfsr_q;
            end
        end
    end

    assign dither = $signed({{(SW-2){1'b0}}, lfsr_frame_q[7:6]}) - $signed(SW'(2));
`else
    assign dither = '0;
`endif

    // Per-channel state: input latch, filter output, previous input and published output.
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic signed [WIDTH-1:0] x_lat_q;
            logic signed [WIDTH-1:0] y_q;
            logic signed [SW-1:0]    xp_q;
            logic signed [WIDTH-1:0] out_q;

            // Latch the input at frame start, update on this channel's RUN slot, publish in DONE.
            always_ff @(posedge clk or negedge I_RSTn) begin
                if (!I_RSTn) begin
                    x_lat_q <= '0;
                    y_q     <= '0;
                    xp_q    <= '0;
                    out_q   <= '0;
                end else begin
                    if (latch_en) begin
                        x_lat_q <= in[gi*WIDTH +: WIDTH];
                    end
                    if (run_en && (ch_q == CHW'(gi))) begin
                        y_q  <= y_next;
                        xp_q <= xp_next;
                    end
                    if (state_q == DONE) begin
                        out_q <= y_q;
                    end
                end
            end

            assign x_all[gi*WIDTH +: WIDTH] = x_lat_q;
            assign y_all[gi*WIDTH +: WIDTH] = y_q;
            assign xp_all[gi*SW +: SW]      = xp_q;
            assign out[gi*WIDTH +: WIDTH]   = out_q;
        end
    endgenerate

    // Shared multiplier: select the active channel and compute its next output with saturation.
    always_comb begin
        x_sel   = x_all[int'(ch_q)*WIDTH +: WIDTH];
        y_sel   = y_all[int'(ch_q)*WIDTH +: WIDTH];
        xp_sel  = xp_all[int'(ch_q)*SW +: SW];
        is_hp   = HP_MASK[ch_q];
        x_e     = {{2{x_sel[WIDTH-1]}}, x_sel};
        y_e     = {{2{y_sel[WIDTH-1]}}, y_sel};
        operand = is_hp ? (y_e + x_e - xp_sel) : (x_e - y_e);
        coef    = is_hp ? A_HP : A_LP;
        prod    = coef * {{(PW-SW){operand[SW-1]}}, operand};
        scaled  = prod >>> 16;
        y_full  = is_hp ? scaled : (scaled + {{(PW-WIDTH){y_sel[WIDTH-1]}}, y_sel});
        if (y_full > MAXV) begin
            y_next = MAXV[WIDTH-1:0];
        end else if (y_full < MINV) begin
            y_next = MINV[WIDTH-1:0];
        end else begin
            y_next = y_full[WIDTH-1:0];
        end
        xp_next = is_hp ? (x_e + dither) : x_e;
    end

    // Frame sequencer next-state: IDLE -> RUN (one channel per clock) -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        case (state_q)
            IDLE: begin
                if (audio_clk_en) begin
                    state_d = RUN;
                    ch_d    = '0;
                end
            end
            RUN: begin
                if (ch_q == CHW'(CHANNELS - 1)) begin
                    state_d = DONE;
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer registers, output-valid pulse and the sticky overrun flag.
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            out_valid_q <= (state_q == DONE);
            if (audio_clk_en && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
        end
    end

endmodule
